// File: rtl/cpu_fetch_issue.sv
// rtl/cpu_fetch_issue.sv - instruction fetch stage publishing tagged, field-decoded instructions to decode
// o_data packs {tag[91:84], pc[83:52], instruction[51:20], rs1[19:15], rs2[14:10], rs3[9:5], rd[4:0]}.
module cpu_fetch_issue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  output logic        o_fault,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_stall,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic [91:0] o_data
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_WAIT_JUMP, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] cnt_q;
  logic        req_q;
  logic        fault_q;
  logic [91:0] data_q;

  logic [6:0]  opcode;
  logic [4:0]  rs1_d, rs2_d, rs3_d, rd_d;
  logic        is_ctrl;

  always_comb begin
    opcode  = instr_q[6:0];
    rs1_d   = instr_q[19:15];
    rs2_d   = instr_q[24:20];
    rs3_d   = 5'd0;
    rd_d    = instr_q[11:7];
    is_ctrl = 1'b0;
    case (opcode)
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: rs3_d = instr_q[31:27];
      7'b0110111, 7'b0010111: begin
        rs1_d = 5'd0;
        rs2_d = 5'd0;
      end
      7'b1101111: begin
        rs1_d   = 5'd0;
        rs2_d   = 5'd0;
        is_ctrl = 1'b1;
      end
      7'b1100111: begin
        rs2_d   = 5'd0;
        is_ctrl = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1110011: rs2_d = 5'd0;
      7'b0100011: rd_d = 5'd0;
      7'b1100011: begin
        rd_d    = 5'd0;
        is_ctrl = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= 92'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // Only the first cycle after reset arrives here without a request already raised.
          if (!req_q) begin
            if (pc_q[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              req_q <= 1'b1;
            end
          end else if (i_bus_ready) begin
            instr_q <= i_bus_rdata;
            req_q   <= 1'b0;
            cnt_q   <= 32'd0;
            state_q <= S_ISSUE;
          end else if (BUS_TIMEOUT != 0 && cnt_q + 32'd1 == BUS_TIMEOUT) begin
            fault_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_HALT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_ISSUE: begin
          if (!i_stall) begin
            data_q <= {data_q[91:84] + 8'd1, pc_q, instr_q, rs1_d, rs2_d, rs3_d, rd_d};
            if (is_ctrl) begin
              state_q <= S_WAIT_JUMP;
            end else begin
              pc_q    <= pc_q + 32'd4;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_WAIT_JUMP: begin
          if (i_jump) begin
            if (i_jump_pc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q    <= i_jump_pc;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fault       = fault_q;
  assign o_bus_request = req_q;
  assign o_bus_address = pc_q;
  assign o_data        = data_q;

endmodule

// File: tb/tb_cpu_fetch_issue.sv
// tb/tb_cpu_fetch_issue.sv - self-checking bench for cpu_fetch_issue against a transaction-level model
module tb_cpu_fetch_issue;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        fault, req, to_fault, to_req;
  logic [31:0] addr, to_addr;
  logic        ready, stall, jump;
  logic [31:0] rdata, jump_pc;
  logic [91:0] data, to_data;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] model_pc;
  logic [7:0]  exp_tag;
  logic [91:0] exp_data;
  logic [6:0]  ops [15] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h03, 7'h73,
                            7'h23, 7'h33, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h0F};

  always #5 clk = ~clk;

  cpu_fetch_issue #(.RESET_PC(32'h100), .BUS_TIMEOUT(0)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .o_fault(fault), .o_bus_request(req),
    .o_bus_address(addr), .i_bus_ready(ready), .i_bus_rdata(rdata), .i_stall(stall),
    .i_jump(jump), .i_jump_pc(jump_pc), .o_data(data));

  cpu_fetch_issue #(.RESET_PC(32'h100), .BUS_TIMEOUT(4)) u_to (
    .i_clock(clk), .i_reset_n(rst2_n), .o_fault(to_fault), .o_bus_request(to_req),
    .o_bus_address(to_addr), .i_bus_ready(1'b0), .i_bus_rdata(32'h0), .i_stall(1'b0),
    .i_jump(1'b0), .i_jump_pc(32'h0), .o_data(to_data));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register fields decode expects: {rs1, rs2, rs3, rd}
  function automatic logic [19:0] ref_fields(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [4:0] r1 = w[19:15], r2 = w[24:20], r3 = 5'd0, d = w[11:7];
    if (op inside {7'h43, 7'h47, 7'h4B, 7'h4F}) r3 = w[31:27];
    if (op inside {7'h37, 7'h17, 7'h6F}) begin r1 = 5'd0; r2 = 5'd0; end
    if (op inside {7'h13, 7'h03, 7'h67, 7'h73}) r2 = 5'd0;
    if (op inside {7'h23, 7'h63}) d = 5'd0;
    return {r1, r2, r3, d};
  endfunction

  task automatic fetch_one(input logic [31:0] w, input int lat, input int nst, input logic [31:0] jpc);
    int n = 0;
    logic [91:0] prev;
    while (!req && n < 20) begin @(negedge clk); n++; end
    check("req_seen", req, 1'b1);
    check("bus_addr", addr, model_pc);
    for (int i = 0; i < lat; i++) begin
      jump    = 1'($urandom_range(0, 1));
      jump_pc = $urandom | 32'h1;
      @(negedge clk);
      check("req_hold", {req, addr}, {1'b1, model_pc});
    end
    jump  = 1'b0;
    ready = 1'b1;
    rdata = w;
    prev  = data;
    @(negedge clk);
    ready = 1'b0;
    rdata = $urandom;
    check("req_drop", req, 1'b0);
    stall = (nst > 0);
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      check("stall_hold", data, prev);
      if (i == nst - 1) stall = 1'b0;
    end
    @(negedge clk);
    exp_tag  = exp_tag + 8'd1;
    exp_data = {exp_tag, model_pc, w, ref_fields(w)};
    check("publish", data, exp_data);
    if (w[6:0] inside {7'h6F, 7'h67, 7'h63}) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        check("wait_no_req", req, 1'b0);
        @(negedge clk);
      end
      jump    = 1'b1;
      jump_pc = jpc;
      @(negedge clk);
      jump = 1'b0;
      if (jpc[1:0] != 2'b00) begin
        check("jump_fault", {fault, req}, 2'b10);
      end else begin
        check("jump_ok", {fault, req}, 2'b01);
        model_pc = jpc;
      end
    end else begin
      model_pc = model_pc + 32'd4;
    end
  endtask

  initial begin
    logic [31:0] w;
    int cnt;
    rst_n = 1'b0; rst2_n = 1'b0;
    ready = 1'b0; stall = 1'b0; jump = 1'b0; rdata = 32'h0; jump_pc = 32'h0;
    model_pc = 32'h100;
    exp_tag  = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {data, req, fault}, 94'd0);
    rst_n = 1'b1;

    fetch_one(32'h00A00093, 2, 0, 32'h0);
    check("first_fields", {data[91:84], data[83:52], data[19:15], data[14:10], data[4:0]},
          {8'd1, 32'h100, 5'd0, 5'd0, 5'd1});
    fetch_one(32'h00500113, 0, 5, 32'h0);
    fetch_one(32'h0000006F, 1, 0, 32'h200);
    fetch_one(32'h00A00093, 1, 0, 32'h0);
    check("after_jump_pc", data[83:52], 32'h200);

    for (int k = 0; k < 120; k++) begin
      w = $urandom;
      cnt = $urandom_range(0, 15);
      if (cnt < 15) w[6:0] = ops[cnt];
      fetch_one(w, $urandom_range(0, 3), ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3),
                $urandom & 32'hFFFF_FFFC);
    end

    for (int k = 0; k < 256; k++) begin
      w = $urandom;
      w[6:0] = 7'h13;
      fetch_one(w, 0, 0, 32'h0);
    end

    fetch_one(32'h00208463, 1, 0, 32'h102);
    for (int i = 0; i < 8; i++) begin
      ready   = 1'b1;
      jump    = 1'($urandom_range(0, 1));
      jump_pc = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      check("halt_frozen", {fault, req, data}, {1'b1, 1'b0, exp_data});
    end
    ready = 1'b0; jump = 1'b0;

    rst2_n = 1'b1;
    cnt = 0;
    while (!to_req && cnt < 10) begin @(negedge clk); cnt++; end
    check("to_req_seen", to_req, 1'b1);
    @(negedge clk);
    #2 rst2_n = 1'b0;
    #1 check("async_reset_drop", {to_req, to_fault}, 2'b00);
    @(negedge clk);
    rst2_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 && !to_fault; i++) begin
      @(negedge clk);
      if (to_req) cnt++;
    end
    check("timeout_cycles", cnt, 4);
    check("timeout_fault", {to_fault, to_req}, 2'b10);
    #2 rst2_n = 1'b0;
    #1 check("timeout_reset", {to_fault, to_req}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
